// File: rtl/switch_port_receiver.sv
// Endpoint side of a switch output link: per-VC flit FIFOs with credit/ack return upstream
// and a round-robin, lock-on-stall valid/ready drain toward local logic.
package switch_port_receiver_pkg;
  localparam int VC_W = 1;

  typedef struct packed {
    logic [3:0]      src;
    logic [VC_W-1:0] vc;
  } metadata_t;

  typedef struct packed {
    metadata_t   metadata;
    logic [31:0] payload;
  } flit_t;
endpackage

module switch_port_receiver
  import switch_port_receiver_pkg::*;
#(
  parameter  int NUM_VCS  = 2,
  parameter  int DEPTH    = 8,
  localparam int OUT_VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                data_ready_in,
  input  flit_t               in,
  output logic                packet_sent,
  output logic [NUM_VCS-1:0]  credit_granted,
  output flit_t               out,
  output logic [OUT_VC_W-1:0] out_vc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(DEPTH - 1);

  flit_t               mem    [NUM_VCS][DEPTH];
  logic [PTR_W-1:0]    rd_ptr [NUM_VCS];
  logic [PTR_W-1:0]    wr_ptr [NUM_VCS];
  logic [CNT_W-1:0]    count  [NUM_VCS];
  logic [OUT_VC_W-1:0] rr_ptr;
  logic [OUT_VC_W-1:0] lock_vc;
  logic                locked;

  logic [OUT_VC_W-1:0] sel_vc;
  logic [OUT_VC_W-1:0] cand;
  logic [OUT_VC_W-1:0] in_vc;
  logic                pop;
  logic                push;
  logic                drop;
  logic [NUM_VCS-1:0]  pop_vec;
  logic [NUM_VCS-1:0]  push_vec;

  // Search order starts just after the last served VC; the loop runs backwards so the
  // nearest non-empty VC is the last (winning) assignment.
  always_comb begin : arbitrate
    sel_vc = rr_ptr;
    cand   = '0;
    if (locked) begin
      sel_vc = lock_vc;
    end else begin
      for (int i = NUM_VCS; i >= 1; i--) begin
        cand = OUT_VC_W'((int'(rr_ptr) + i) % NUM_VCS);
        if (count[cand] != '0) sel_vc = cand;
      end
    end
  end

  // Handshake: out_valid means out/out_vc hold a buffered flit; a transfer (pop) happens on
  // every rising edge where out_valid && out_ready. Once out_valid is shown, the flit stays
  // presented unchanged until it is taken.
  always_comb begin : drain_side
    out_valid = (count[sel_vc] != '0);
    out       = out_valid ? mem[sel_vc][rd_ptr[sel_vc]] : '0;
    out_vc    = out_valid ? sel_vc : '0;
    pop       = out_valid && out_ready;
    pop_vec   = pop ? (NUM_VCS'(1) << sel_vc) : '0;
  end

  // A full VC still accepts when its head leaves in the same cycle.
  always_comb begin : fill_side
    in_vc    = OUT_VC_W'(in.metadata.vc);
    push     = data_ready_in && ((count[in_vc] != FULL) || (pop && (sel_vc == in_vc)));
    drop     = data_ready_in && !push;
    push_vec = push ? (NUM_VCS'(1) << in_vc) : '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[in_vc][wr_ptr[in_vc]] <= in;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
      rr_ptr         <= '0;
      lock_vc        <= '0;
      locked         <= 1'b0;
      packet_sent    <= 1'b0;
      credit_granted <= '0;
      overflow_err   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (push_vec[v]) wr_ptr[v] <= (wr_ptr[v] == PTR_TOP) ? '0 : wr_ptr[v] + 1'b1;
        if (pop_vec[v])  rd_ptr[v] <= (rd_ptr[v] == PTR_TOP) ? '0 : rd_ptr[v] + 1'b1;
        if (push_vec[v] && !pop_vec[v])      count[v] <= count[v] + 1'b1;
        else if (pop_vec[v] && !push_vec[v]) count[v] <= count[v] - 1'b1;
      end
      if (pop) begin
        rr_ptr <= sel_vc;
        locked <= 1'b0;
      end else if (out_valid) begin
        locked  <= 1'b1;
        lock_vc <= sel_vc;
      end
      packet_sent    <= push;
      credit_granted <= pop_vec;
      overflow_err   <= overflow_err | drop;
    end
  end

endmodule
